// File: rtl/cnnip_mem_pkg.sv
// cnnip_mem_pkg: shared request classification, latency limit and byte-lane helper for the cnnip_mem_if slave
package cnnip_mem_pkg;
  localparam int MAX_READ_LATENCY = 8;
  typedef enum logic [1:0] {MEM_IDLE, MEM_READ, MEM_WRITE} mem_op_e;
  function automatic int num_bytes(input int dw);
    return ((dw - 1) >> 3) + 1;
  endfunction
endpackage

// File: rtl/cnnip_delay_line.sv
// cnnip_delay_line: DEPTH-stage valid+data pipe (clk, rstn, src_valid/src_data in, dst_valid/dst_data out); only valid resets, DEPTH=0 is a wire
module cnnip_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             dst_valid,
  output logic [WIDTH-1:0] dst_data
);
  if (DEPTH == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk ^ rstn;
    assign dst_valid = src_valid;
    assign dst_data = src_data;
  end else begin : g_pipe
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) v_q <= '0;
      else begin
        v_q[0] <= src_valid;
        for (int i = 1; i < DEPTH; i++) v_q[i] <= v_q[i-1];
      end
    always_ff @(posedge clk) begin
      d_q[0] <= src_data;
      for (int i = 1; i < DEPTH; i++) d_q[i] <= d_q[i-1];
    end
    assign dst_valid = v_q[DEPTH-1];
    assign dst_data = d_q[DEPTH-1];
  end
endmodule

// File: rtl/cnnip_bram_slave.sv
// cnnip_bram_slave: byte-masked single-port memory slave (clk, rstn, en/we/addr/din request in, dout/valid read response out after READ_LATENCY)
module cnnip_bram_slave
  import cnnip_mem_pkg::*;
#(
  parameter int    ADDR_WIDTH   = 12,
  parameter int    DATA_WIDTH   = 32,
  parameter int    READ_LATENCY = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             en,
  input  logic [num_bytes(DATA_WIDTH)-1:0] we,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            din,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             valid
);
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("cnnip_bram_slave: READ_LATENCY %0d outside 1..%0d", READ_LATENCY, MAX_READ_LATENCY);
  end
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] dl_data;
  logic dl_valid;
  mem_op_e op;
  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_mask
    assign wmask[g] = we[g/8];
  end
  always_comb op = !en ? MEM_IDLE : (|we ? MEM_WRITE : MEM_READ);
  always_ff @(posedge clk)
    if (op == MEM_WRITE) mem[addr] <= (mem[addr] & ~wmask) | (din & wmask);
  cnnip_delay_line #(.WIDTH(DATA_WIDTH), .DEPTH(READ_LATENCY - 1)) u_delay (
    .clk      (clk),
    .rstn     (rstn),
    .src_valid(op == MEM_READ),
    .src_data (mem[addr]),
    .dst_valid(dl_valid),
    .dst_data (dl_data)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      valid <= 1'b0;
      dout <= '0;
    end else begin
      valid <= dl_valid;
      if (dl_valid) dout <= dl_data;
    end
`ifndef SYNTHESIS
  a_req_known: assert property (@(posedge clk) disable iff (!rstn) !$isunknown({en, we}))
    else $error("cnnip_bram_slave: unknown value on en/we");
`endif
endmodule

// File: tb/tb_cnnip_bram_slave.sv
// tb_cnnip_bram_slave: scoreboard bench driving READ_LATENCY 2, 1 and 5 instances with one shared request stream
module tb_cnnip_bram_slave;
  typedef struct {
    logic [31:0] d;
    int          iss;
  } exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic [3:0] we = '0;
  logic [11:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout_a [3];
  logic valid_a [3];
  int lat [3] = '{2, 1, 5};
  int head [3] = '{0, 0, 0};
  exp_t q [$];
  logic [31:0] model [int];
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  cnnip_bram_slave #(.READ_LATENCY(2)) dut_l2 (
    .clk(clk), .rstn(rstn), .en(en), .we(we), .addr(addr), .din(din), .dout(dout_a[0]), .valid(valid_a[0]));
  cnnip_bram_slave #(.READ_LATENCY(1)) dut_l1 (
    .clk(clk), .rstn(rstn), .en(en), .we(we), .addr(addr), .din(din), .dout(dout_a[1]), .valid(valid_a[1]));
  cnnip_bram_slave #(.READ_LATENCY(5)) dut_l5 (
    .clk(clk), .rstn(rstn), .en(en), .we(we), .addr(addr), .din(din), .dout(dout_a[2]), .valid(valid_a[2]));
  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      if (valid_a[k]) begin
        checks++;
        if (head[k] >= q.size()) begin
          fails++;
          $display("FAIL spurious_valid lat%0d cyc %0d: valid=1 with no read outstanding", lat[k], cyc);
        end else begin
          if (dout_a[k] !== q[head[k]].d || cyc != q[head[k]].iss + lat[k]) begin
            fails++;
            $display("FAIL read_data lat%0d: got %h at cyc %0d, required %h at cyc %0d",
                     lat[k], dout_a[k], cyc, q[head[k]].d, q[head[k]].iss + lat[k]);
          end
          head[k]++;
        end
      end else if (head[k] < q.size() && cyc > q[head[k]].iss + lat[k]) begin
        checks++;
        fails++;
        $display("FAIL missing_valid lat%0d: no valid by cyc %0d, required at cyc %0d with %h",
                 lat[k], cyc, q[head[k]].iss + lat[k], q[head[k]].d);
        head[k]++;
      end
    end
  task automatic req(input logic e, input logic [3:0] w, input logic [11:0] a, input logic [31:0] d);
    logic [31:0] m;
    exp_t x;
    @(negedge clk);
    en = e;
    we = w;
    addr = a;
    din = d;
    if (e && w == 4'h0) begin
      x.d = model[int'(a)];
      x.iss = cyc;
      q.push_back(x);
    end else if (e) begin
      m = model.exists(int'(a)) ? model[int'(a)] : 32'h0;
      for (int i = 0; i < 4; i++) if (w[i]) m[8*i +: 8] = d[8*i +: 8];
      model[int'(a)] = m;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) req(1'b0, 4'h0, 12'h0, 32'h0);
  endtask
  task automatic test_reset;
    rstn = 1'b0;
    en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (valid_a[k] !== 1'b0 || dout_a[k] !== 32'h0) begin
          fails++;
          $display("FAIL reset_hold lat%0d: valid=%b dout=%h, required 0/00000000", lat[k], valid_a[k], dout_a[k]);
        end
      end
    end
    rstn = 1'b1;
    repeat (10) begin
      idle(1);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (valid_a[k] !== 1'b0 || dout_a[k] !== 32'h0) begin
          fails++;
          $display("FAIL reset_idle lat%0d: valid=%b dout=%h, required 0/00000000", lat[k], valid_a[k], dout_a[k]);
        end
      end
    end
  endtask
  task automatic test_byte_write;
    req(1'b1, 4'hF, 12'h010, 32'hAABBCCDD);
    req(1'b1, 4'b0101, 12'h010, 32'h11223344);
    req(1'b1, 4'h0, 12'h010, 32'h0);
    idle(2);
    checks++;
    if (valid_a[0] !== 1'b1 || dout_a[0] !== 32'hAA22CC44) begin
      fails++;
      $display("FAIL byte_write: valid=%b dout=%h, required 1/aa22cc44", valid_a[0], dout_a[0]);
    end
    idle(6);
  endtask
  task automatic test_back_to_back;
    for (int k = 0; k < 8; k++) req(1'b1, 4'hF, 12'(k), 32'(k) * 32'h01010101);
    for (int k = 0; k < 8; k++) req(1'b1, 4'h0, 12'(k), 32'h0);
    idle(8);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (valid_a[k] !== 1'b0 || dout_a[k] !== 32'h07070707 || head[k] != q.size()) begin
        fails++;
        $display("FAIL b2b_hold lat%0d: valid=%b dout=%h pending=%0d, required 0/07070707/0",
                 lat[k], valid_a[k], dout_a[k], q.size() - head[k]);
      end
    end
  endtask
  task automatic test_hazard;
    req(1'b1, 4'hF, 12'h3FF, 32'hDEADBEEF);
    req(1'b1, 4'h0, 12'h3FF, 32'h0);
    req(1'b1, 4'hF, 12'h3FF, 32'h0);
    idle(1);
    checks++;
    if (valid_a[0] !== 1'b1 || dout_a[0] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL hazard: valid=%b dout=%h, required 1/deadbeef", valid_a[0], dout_a[0]);
    end
    idle(6);
  endtask
  task automatic test_reset_midflight;
    req(1'b1, 4'h0, 12'h010, 32'h0);
    req(1'b1, 4'h0, 12'h3FF, 32'h0);
    @(negedge clk);
    en = 1'b0;
    #1 rstn = 1'b0;
    for (int k = 0; k < 3; k++) head[k] = q.size();
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (valid_a[k] !== 1'b0 || dout_a[k] !== 32'h0) begin
          fails++;
          $display("FAIL midflight_reset lat%0d: valid=%b dout=%h, required 0/00000000", lat[k], valid_a[k], dout_a[k]);
        end
      end
    end
    rstn = 1'b1;
    repeat (6) begin
      idle(1);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (valid_a[k] !== 1'b0 || dout_a[k] !== 32'h0) begin
          fails++;
          $display("FAIL midflight_flush lat%0d: valid=%b dout=%h, required 0/00000000", lat[k], valid_a[k], dout_a[k]);
        end
      end
    end
    req(1'b1, 4'h0, 12'h010, 32'h0);
    idle(2);
    checks++;
    if (valid_a[0] !== 1'b1 || dout_a[0] !== 32'hAA22CC44) begin
      fails++;
      $display("FAIL survive_reset: valid=%b dout=%h, required 1/aa22cc44", valid_a[0], dout_a[0]);
    end
    idle(6);
  endtask
  task automatic test_drain;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (head[k] != q.size()) begin
        fails++;
        $display("FAIL drain lat%0d: %0d reads undelivered, required 0", lat[k], q.size() - head[k]);
      end
    end
  endtask
  initial begin
    test_reset;
    test_byte_write;
    test_back_to_back;
    test_hazard;
    test_reset_midflight;
    test_drain;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
